// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// state encoding and an elaboration-time ceil(log2) helper.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WORK = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_dff.sv
// Parametrised N-bit register with load enable and asynchronous active-low reset to zero.
module shift_add_multiplier_dff #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_add_multiplier_sign_magnitude.sv
// Converts a WIDTH-bit operand into its unsigned magnitude and a sign bit;
// in unsigned mode the raw value passes through with sign 0.
module shift_add_multiplier_sign_magnitude #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] magnitude,
  output logic             negative
);

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    negative = signed_mode & value[WIDTH-1];
    if (negative) begin
      magnitude = (~value) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = value;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier with signed/unsigned mode, optional early
// termination and a four-phase start/done handshake. All outputs are registered.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  logic [1:0]       state_d,   state_q;
  logic [PW-1:0]    mcand_d,   mcand_q;
  logic [WIDTH-1:0] mplier_d,  mplier_q;
  logic [PW-1:0]    acc_d,     acc_q;
  logic [CW-1:0]    cnt_d,     cnt_q;
  logic             sign_d,    sign_q;
  logic [PW-1:0]    product_d, product_q;
  logic             busy_d,    busy_q;
  logic             done_d,    done_q;

  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic             neg_a_s, neg_b_s;
  logic [PW-1:0]    acc_nxt_s;
  logic [WIDTH-1:0] mplier_sh_s;
  logic             last_s;

  shift_add_multiplier_sign_magnitude #(.WIDTH(WIDTH)) u_sm_a (
    .value       (multiplicand),
    .signed_mode (signed_mode),
    .magnitude   (mag_a_s),
    .negative    (neg_a_s)
  );

  shift_add_multiplier_sign_magnitude #(.WIDTH(WIDTH)) u_sm_b (
    .value       (multiplier),
    .signed_mode (signed_mode),
    .magnitude   (mag_b_s),
    .negative    (neg_b_s)
  );

  // Next-state and datapath update for one clock.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;

    acc_nxt_s   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_sh_s = mplier_q >> 1;
    last_s      = (cnt_q == CW'(WIDTH - 1)) ||
                  ((EARLY_TERM != 0) && (mplier_sh_s == '0));

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a_s};
          mplier_d = mag_b_s;
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = neg_a_s ^ neg_b_s;
          state_d  = WORK;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b0;
        end
      end
      WORK: begin
        acc_d    = acc_nxt_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh_s;
        cnt_d    = cnt_q + CW'(1);
        if (last_s) begin
          product_d = sign_q ? (-acc_nxt_s) : acc_nxt_s;
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      DONE: begin
        // Product is kept after leaving DONE until the next completion.
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  shift_add_multiplier_dff #(.N(2))     u_state_r   (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_d),   .q(state_q));
  shift_add_multiplier_dff #(.N(PW))    u_mcand_r   (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(mcand_d),   .q(mcand_q));
  shift_add_multiplier_dff #(.N(WIDTH)) u_mplier_r  (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(mplier_d),  .q(mplier_q));
  shift_add_multiplier_dff #(.N(PW))    u_acc_r     (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(acc_d),     .q(acc_q));
  shift_add_multiplier_dff #(.N(CW))    u_cnt_r     (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(cnt_d),     .q(cnt_q));
  shift_add_multiplier_dff #(.N(1))     u_sign_r    (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(sign_d),    .q(sign_q));
  shift_add_multiplier_dff #(.N(PW))    u_product_r (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(product_d), .q(product_q));
  shift_add_multiplier_dff #(.N(1))     u_busy_r    (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(busy_d),    .q(busy_q));
  shift_add_multiplier_dff #(.N(1))     u_done_r    (.clk(clk), .rst_n(rst_n), .en(1'b1), .d(done_d),    .q(done_q));

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: one instance with early termination,
// one without; expected products come from a queue filled when each operation starts.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start0 = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  multiplicand = 8'h00;
  logic [7:0]  multiplier = 8'h00;
  logic [15:0] product1, product0;
  logic        busy1, busy0, done1, done0;

  int passes = 0;
  int total  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8), .EARLY_TERM(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product1), .busy(busy1), .done(done1)
  );

  shift_add_multiplier #(.WIDTH(8), .EARLY_TERM(0)) dut_noet (
    .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(signed_mode),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product0), .busy(busy0), .done(done0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [15:0] model(input bit s, input logic [7:0] a, input logic [7:0] b);
    int pa, pb;
    if (s) begin
      pa = $signed(a);
      pb = $signed(b);
    end else begin
      pa = int'(a);
      pb = int'(b);
    end
    return 16'(pa * pb);
  endfunction

  // Runs one operation; noet selects the EARLY_TERM=0 instance.
  task automatic run_op(input string tag, input bit noet, input bit s,
                        input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input int hold, input bit scramble);
    logic [15:0] expv;
    int lat;
    bit seen;
    exp_q.push_back(model(s, a, b));
    @(negedge clk);
    signed_mode  = s;
    multiplicand = a;
    multiplier   = b;
    if (noet) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy after E0"}, noet ? busy0 : busy1, 1'b1);
    check({tag, " done after E0"}, noet ? done0 : done1, 1'b0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (scramble) begin
        multiplicand = ~a;
        multiplier   = ~b;
        signed_mode  = ~s;
      end
      if (noet ? done0 : done1) seen = 1'b1;
      else check({tag, " busy in work"}, noet ? busy0 : busy1, 1'b1);
    end
    check({tag, " done seen"}, seen, 1'b1);
    check({tag, " latency"}, lat, exp_lat);
    expv = exp_q.pop_front();
    check({tag, " product"}, noet ? product0 : product1, expv);
    check({tag, " busy at done"}, noet ? busy0 : busy1, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold done"}, noet ? done0 : done1, 1'b1);
      check({tag, " hold product"}, noet ? product0 : product1, expv);
      check({tag, " hold busy"}, noet ? busy0 : busy1, 1'b0);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    @(posedge clk); #1;
    check({tag, " done drop"}, noet ? done0 : done1, 1'b0);
    check({tag, " product kept"}, noet ? product0 : product1, expv);
  endtask

  initial begin
    #12;
    check("reset product", product1, 16'h0000);
    check("reset busy", busy1, 1'b0);
    check("reset done", done1, 1'b0);
    check("reset product noet", product0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("u255x255", 1'b0, 1'b0, 8'd255, 8'd255, 8, 0, 1'b0);
    check("u255x255 value", product1, 16'hFE01);
    run_op("s-128x-128", 1'b0, 1'b1, 8'h80, 8'h80, 8, 0, 1'b0);
    check("s-128x-128 value", product1, 16'h4000);
    run_op("s127x-128", 1'b0, 1'b1, 8'h7F, 8'h80, 8, 0, 1'b0);
    check("s127x-128 value", product1, 16'hC080);
    run_op("s-3x5", 1'b0, 1'b1, 8'hFD, 8'h05, 3, 0, 1'b0);
    check("s-3x5 value", product1, 16'hFFF1);
    run_op("s-3x5 noet", 1'b1, 1'b1, 8'hFD, 8'h05, 8, 0, 1'b0);
    check("s-3x5 noet value", product0, 16'hFFF1);
    run_op("u77x0", 1'b0, 1'b0, 8'd77, 8'd0, 1, 0, 1'b0);
    run_op("u0x200", 1'b0, 1'b0, 8'd0, 8'd200, 8, 0, 1'b0);
    run_op("u13x6 hold", 1'b0, 1'b0, 8'd13, 8'd6, 3, 5, 1'b0);
    check("u13x6 value", product1, 16'd78);
    run_op("u100x37 scramble", 1'b0, 1'b0, 8'd100, 8'd37, 6, 0, 1'b0);
    run_op("u100x37 mid-change", 1'b0, 1'b0, 8'd100, 8'd37, 6, 0, 1'b1);
    check("mid-change value", product1, 16'h0E74);

    // Asynchronous reset between edges while the multiply is in progress.
    @(negedge clk);
    signed_mode  = 1'b0;
    multiplicand = 8'd255;
    multiplier   = 8'd255;
    start1       = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    check("pre-reset busy", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy1, 1'b0);
    check("async reset done", done1, 1'b0);
    check("async reset product", product1, 16'h0000);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset idle busy", busy1, 1'b0);
    run_op("u12x11", 1'b0, 1'b0, 8'd12, 8'd11, 4, 0, 1'b0);
    check("u12x11 value", product1, 16'h0084);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
